// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command path: state encoding and default
// opcode / width values used by the sequencer and the shift-register block.
package spi_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  localparam logic [7:0] DEF_CMD_READ  = 8'h03;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RFETCH = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Synchronous memory port between the SPI command sequencer and the
// register/memory array.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = spi_pkg::DEF_ADDR_W,
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);
  // mem_we / mem_re are single-cycle strobes, never high together, qualified
  // by mem_addr (and mem_wdata for writes) in the same cycle; mem_rdata must
  // be valid exactly one cycle after mem_re and is not held afterwards.
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/spi_bit_cnt.sv
// Bit-within-byte counter for the SPI sequencer; flags the strobe that
// completes each byte.
module spi_bit_cnt (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  output logic byte_done
);

  logic [2:0] cnt;

  // A clearing cycle never completes a byte, so an aborted 8th bit is lost.
  assign byte_done = bit_valid && !clr && (cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (bit_valid) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI-slave command sequencer: decodes READ/WRITE opcode, 16-bit address and
// burst data bytes, drives a synchronous memory port and shifts reads onto miso.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         DATA_W    = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs_n,
  input  logic           bit_valid,
  input  logic           bit_in,
  output logic           miso,
  output logic           busy,
  output logic           cmd_err,
  output state_t         state,
  spi_cmd_ctrl_if.master mem
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int AB_W       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  // Only the seven most recent bits are stored; the incoming bit completes the byte.
  logic [6:0]        rx_shift;
  logic [7:0]        rx_byte;
  logic [DATA_W-1:0] tx_shift;
  logic [ADDR_W-1:0] addr_acc;
  logic [AB_W-1:0]   addr_byte;
  logic              rd_flag;
  logic              byte_done;
  logic              cnt_clr;

  assign rx_byte = {rx_shift, bit_in};
  assign cnt_clr = cs_n || (state == ST_IDLE);
  assign miso    = tx_shift[DATA_W-1];
  assign busy    = (state != ST_IDLE);

  spi_bit_cnt u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .bit_valid (bit_valid),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rx_shift      <= '0;
      tx_shift      <= '0;
      addr_acc      <= '0;
      addr_byte     <= '0;
      rd_flag       <= 1'b0;
      cmd_err       <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_re    <= 1'b0;
    end else begin
      mem.mem_we <= 1'b0;
      mem.mem_re <= 1'b0;
      cmd_err    <= 1'b0;

      if (bit_valid) begin
        rx_shift <= rx_byte[6:0];
      end

      // The write issued last cycle advances the burst address, even on abort.
      if (mem.mem_we) begin
        mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
      end

      if (cs_n) begin
        state    <= ST_IDLE;
        tx_shift <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            addr_acc  <= '0;
            addr_byte <= '0;
            state     <= ST_CMD;
          end

          ST_CMD: begin
            if (byte_done) begin
              if (rx_byte == CMD_READ) begin
                rd_flag <= 1'b1;
                state   <= ST_ADDR;
              end else if (rx_byte == CMD_WRITE) begin
                rd_flag <= 1'b0;
                state   <= ST_ADDR;
              end else begin
                cmd_err <= 1'b1;
                state   <= ST_IGNORE;
              end
            end
          end

          ST_ADDR: begin
            if (byte_done) begin
              if (addr_byte == AB_W'(ADDR_BYTES - 1)) begin
                mem.mem_addr <= (addr_acc << 8) | ADDR_W'(rx_byte);
                addr_byte    <= '0;
                if (rd_flag) begin
                  mem.mem_re <= 1'b1;
                  state      <= ST_RFETCH;
                end else begin
                  state <= ST_WDATA;
                end
              end else begin
                addr_acc  <= (addr_acc << 8) | ADDR_W'(rx_byte);
                addr_byte <= addr_byte + AB_W'(1);
              end
            end
          end

          ST_WDATA: begin
            if (byte_done) begin
              mem.mem_wdata <= rx_byte;
              mem.mem_we    <= 1'b1;
            end
          end

          // First cycle has mem_re high; the second captures mem_rdata.
          ST_RFETCH: begin
            if (!mem.mem_re) begin
              tx_shift <= mem.mem_rdata;
              state    <= ST_RDATA;
            end
          end

          ST_RDATA: begin
            if (bit_valid) begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              if (byte_done) begin
                mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
                mem.mem_re   <= 1'b1;
                state        <= ST_RFETCH;
              end
            end
          end

          ST_IGNORE: begin
            state <= ST_IGNORE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed and random SPI transactions checked against
// a bit-indexed transaction model and a reference memory image.
module tb_spi_cmd_ctrl;
  import spi_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   cs_n = 1'b1;
  logic   bit_valid = 1'b0;
  logic   bit_in = 1'b0;
  logic   miso;
  logic   busy;
  logic   cmd_err;
  state_t state;

  spi_cmd_ctrl_if m ();

  spi_cmd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .miso      (miso),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .state     (state),
    .mem       (m)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory slave ----------------
  logic [7:0] mem_arr [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (m.mem_we) mem_arr[m.mem_addr] <= m.mem_wdata;
    if (m.mem_re) m.mem_rdata <= mem_arr[m.mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  tx_q[$];
  logic [23:0] exp_wr_q[$];
  logic [23:0] obs_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] obs_rd_q[$];
  string       exp_miso_s, obs_miso_s;
  string       exp_wr_s, obs_wr_s, exp_rd_s, obs_rd_s;
  int          exp_err, err_obs;
  int          overlap = 0;
  logic        busy_at_rise, busy_after;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m.mem_we) obs_wr_q.push_back({m.mem_addr, m.mem_wdata});
      if (m.mem_re) obs_rd_q.push_back(m.mem_addr);
      if (cmd_err) err_obs++;
      if (m.mem_we && m.mem_re) overlap++;
    end
  end

  // Expected effect of a transaction of nb_tot clocked bits, of which the
  // first nb_eff count (an 8th bit coinciding with cs_n rising does not).
  task automatic model_txn(input int nb_eff, input int nb_tot);
    logic [7:0]  op, d;
    logic [15:0] a;
    logic        rd, wr, bb;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_err    = 0;
    exp_miso_s = "";
    op = tx_q[0];
    rd = (op == 8'h03);
    wr = (op == 8'h02);
    a  = {tx_q[1], tx_q[2]};
    if (nb_eff >= 8 && !rd && !wr) exp_err = 1;
    if ((rd || wr) && nb_eff >= 24) begin
      if (rd) exp_rd_q.push_back(a);
      for (int k = 0; 24 + 8 * (k + 1) <= nb_eff; k++) begin
        if (rd) begin
          exp_rd_q.push_back(a + 16'(k + 1));
        end else begin
          exp_wr_q.push_back({a + 16'(k), tx_q[3 + k]});
          ref_mem[a + 16'(k)] = tx_q[3 + k];
        end
      end
    end
    for (int i = 0; i < nb_tot; i++) begin
      bb = 1'b0;
      if (rd && nb_eff >= 24 && i >= 24) begin
        d  = ref_mem[a + 16'((i - 24) / 8)];
        bb = d[7 - ((i - 24) % 8)];
      end
      exp_miso_s = $sformatf("%s%0b", exp_miso_s, bb);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_bit(input logic b, input logic abort_now);
    obs_miso_s = $sformatf("%s%0b", obs_miso_s, miso);
    bit_valid = 1'b1;
    bit_in    = b;
    if (abort_now) cs_n = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    if (!abort_now) repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input int nbits, input bit abort_last);
    logic [7:0] cur;
    model_txn(abort_last ? nbits - 1 : nbits, nbits);
    obs_wr_q.delete();
    obs_rd_q.delete();
    err_obs    = 0;
    obs_miso_s = "";
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cur = tx_q[i / 8];
      if (abort_last && i == nbits - 1) busy_at_rise = busy;
      send_bit(cur[7 - (i % 8)], abort_last && i == nbits - 1);
    end
    if (!abort_last) begin
      repeat (3) @(negedge clk);
      busy_at_rise = busy;
      cs_n = 1'b1;
      @(negedge clk);
    end
    busy_after = busy;
    repeat (3) @(negedge clk);
    exp_wr_s = ""; obs_wr_s = ""; exp_rd_s = ""; obs_rd_s = "";
    foreach (exp_wr_q[i]) exp_wr_s = $sformatf("%s%h ", exp_wr_s, exp_wr_q[i]);
    foreach (obs_wr_q[i]) obs_wr_s = $sformatf("%s%h ", obs_wr_s, obs_wr_q[i]);
    foreach (exp_rd_q[i]) exp_rd_s = $sformatf("%s%h ", exp_rd_s, exp_rd_q[i]);
    foreach (obs_rd_q[i]) obs_rd_s = $sformatf("%s%h ", obs_rd_s, obs_rd_q[i]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if ({miso, busy, cmd_err, m.mem_we, m.mem_re} !== 5'b0) $display("FAIL reset_outputs: got %b want 00000", {miso, busy, cmd_err, m.mem_we, m.mem_re}); else pass_cnt++;
    chk_cnt++; if ({m.mem_addr, m.mem_wdata} !== 24'h0) $display("FAIL reset_addr_wdata: got %h want 000000", {m.mem_addr, m.mem_wdata}); else pass_cnt++;
    chk_cnt++; if (state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); else pass_cnt++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_write_single();
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hA5};
    run_txn(32, 1'b0);
    chk_cnt++; if (obs_wr_s != "1234a5 ") $display("FAIL write_single_wr: got '%s' want '1234a5 '", obs_wr_s); else pass_cnt++;
    chk_cnt++; if (obs_rd_s != exp_rd_s) $display("FAIL write_single_rd: got '%s' want '%s'", obs_rd_s, exp_rd_s); else pass_cnt++;
    chk_cnt++; if ({busy_at_rise, busy_after} !== 2'b10) $display("FAIL write_single_busy: got %b want 10", {busy_at_rise, busy_after}); else pass_cnt++;
    chk_cnt++; if (obs_miso_s != exp_miso_s) $display("FAIL write_single_miso: got %s want %s", obs_miso_s, exp_miso_s); else pass_cnt++;
  endtask

  task automatic test_read_burst();
    mem_arr[16'h0010] <= 8'h5A; ref_mem[16'h0010] = 8'h5A;
    mem_arr[16'h0011] <= 8'hC3; ref_mem[16'h0011] = 8'hC3;
    tx_q = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
    run_txn(40, 1'b0);
    chk_cnt++; if (obs_miso_s != {"000000000000000000000000", "0101101011000011"}) $display("FAIL read_burst_miso: got %s want %s", obs_miso_s, exp_miso_s); else pass_cnt++;
    chk_cnt++; if (obs_rd_s != exp_rd_s) $display("FAIL read_burst_rd: got '%s' want '%s'", obs_rd_s, exp_rd_s); else pass_cnt++;
    chk_cnt++; if (obs_wr_q.size() != 0) $display("FAIL read_burst_wr: got %0d writes want 0", obs_wr_q.size()); else pass_cnt++;
    chk_cnt++; if (busy_after !== 1'b0) $display("FAIL read_burst_busy: got %b want 0", busy_after); else pass_cnt++;
  endtask

  task automatic test_wrap();
    tx_q = '{8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22};
    run_txn(40, 1'b0);
    chk_cnt++; if (obs_wr_s != "ffff11 000022 ") $display("FAIL wrap_wr: got '%s' want 'ffff11 000022 '", obs_wr_s); else pass_cnt++;
    chk_cnt++; if (obs_wr_s != exp_wr_s) $display("FAIL wrap_model: got '%s' want '%s'", obs_wr_s, exp_wr_s); else pass_cnt++;
  endtask

  task automatic test_bad_opcode();
    tx_q = '{8'h9F, 8'h12, 8'h34, 8'h56};
    run_txn(32, 1'b0);
    chk_cnt++; if (err_obs != 1) $display("FAIL bad_op_err: got %0d pulses want 1", err_obs); else pass_cnt++;
    chk_cnt++; if (obs_wr_q.size() + obs_rd_q.size() != 0) $display("FAIL bad_op_strobes: got %0d want 0", obs_wr_q.size() + obs_rd_q.size()); else pass_cnt++;
    chk_cnt++; if (obs_miso_s != exp_miso_s) $display("FAIL bad_op_miso: got %s want %s", obs_miso_s, exp_miso_s); else pass_cnt++;
  endtask

  task automatic test_abort();
    tx_q = '{8'h02, 8'hAB, 8'hCD, 8'hE7};
    run_txn(29, 1'b0);
    chk_cnt++; if (obs_wr_q.size() != 0) $display("FAIL abort_partial_wr: got %0d writes want 0", obs_wr_q.size()); else pass_cnt++;
    tx_q = '{8'h02, 8'h00, 8'h20, 8'h3C};
    run_txn(32, 1'b0);
    chk_cnt++; if (obs_wr_s != "00203c ") $display("FAIL abort_next_wr: got '%s' want '00203c '", obs_wr_s); else pass_cnt++;
  endtask

  task automatic test_abort_same_cycle();
    tx_q = '{8'h02, 8'h00, 8'h40, 8'h77};
    run_txn(32, 1'b1);
    chk_cnt++; if (obs_wr_q.size() != 0) $display("FAIL abort8_wr: got %0d writes want 0", obs_wr_q.size()); else pass_cnt++;
    chk_cnt++; if ({busy_at_rise, busy_after} !== 2'b10) $display("FAIL abort8_busy: got %b want 10", {busy_at_rise, busy_after}); else pass_cnt++;
    tx_q = '{8'h03, 8'h00, 8'h40, 8'h00};
    run_txn(32, 1'b0);
    chk_cnt++; if (obs_miso_s != exp_miso_s) $display("FAIL abort8_readback: got %s want %s", obs_miso_s, exp_miso_s); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int         r, nd, part;
      bit         ab;
      logic [7:0] op;
      r  = $urandom_range(0, 3);
      op = (r < 2) ? 8'h02 : 8'h03;
      if (r == 3) begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h02 || op == 8'h03) op = 8'hA0;
      end
      nd   = $urandom_range(0, 3);
      part = $urandom_range(0, 7);
      tx_q.delete();
      tx_q.push_back(op);
      for (int j = 0; j < nd + 3; j++) tx_q.push_back(8'($urandom));
      ab = (part == 0 && nd > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(24 + 8 * nd + part, ab);
      chk_cnt++; if (obs_wr_s != exp_wr_s) $display("FAIL rand%0d_wr: got '%s' want '%s'", t, obs_wr_s, exp_wr_s); else pass_cnt++;
      chk_cnt++; if (obs_rd_s != exp_rd_s) $display("FAIL rand%0d_rd: got '%s' want '%s'", t, obs_rd_s, exp_rd_s); else pass_cnt++;
      chk_cnt++; if (obs_miso_s != exp_miso_s) $display("FAIL rand%0d_miso: got %s want %s", t, obs_miso_s, exp_miso_s); else pass_cnt++;
      chk_cnt++; if (err_obs != exp_err) $display("FAIL rand%0d_err: got %0d want %0d", t, err_obs, exp_err); else pass_cnt++;
      chk_cnt++; if (busy_after !== 1'b0) $display("FAIL rand%0d_busy: got %b want 0", t, busy_after); else pass_cnt++;
    end
    chk_cnt++; if (overlap != 0) $display("FAIL we_re_overlap: got %0d cycles want 0", overlap); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] cur, d;
    mem_arr[16'h0200] <= 8'hFF;
    ref_mem[16'h0200] = 8'hFF;
    d = ref_mem[16'h0200];
    tx_q = '{8'h03, 8'h02, 8'h00, 8'h00};
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 27; i++) begin
      cur = tx_q[i / 8];
      send_bit(cur[7 - (i % 8)], 1'b0);
    end
    chk_cnt++; if (miso !== d[4]) $display("FAIL pre_reset_miso: got %b want %b", miso, d[4]); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if ({miso, busy, cmd_err, m.mem_we, m.mem_re} !== 5'b0) $display("FAIL async_reset_outputs: got %b want 00000", {miso, busy, cmd_err, m.mem_we, m.mem_re}); else pass_cnt++;
    chk_cnt++; if (state !== ST_IDLE) $display("FAIL async_reset_state: got %0d want %0d", state, ST_IDLE); else pass_cnt++;
    chk_cnt++; if (m.mem_addr !== 16'h0) $display("FAIL async_reset_addr: got %h want 0000", m.mem_addr); else pass_cnt++;
    cs_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem_arr[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_single();
    test_read_burst();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_abort_same_cycle();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
SPI-slave command sequencer: consumes the serial bit stream sampled from MOSI and sequences a command byte, a 16-bit address and data bytes. It drives a simple synchronous memory port and returns read data serially on MISO. It sits between the SPI pin-level sampler and the on-chip register/memory array, and supports READ (0x03) and WRITE (0x02) with address auto-increment bursts.

Parameters:
CMD_READ, 8'h03, opcode for a read burst
CMD_WRITE, 8'h02, opcode for a write burst
ADDR_W, 16, address width; must be a multiple of 8
DATA_W, 8, data byte width; fixed at 8 in this revision

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cs_n  input  1  chip select, active low, already synchronised to clk
bit_valid  input  1  one-cycle strobe per sampled SCLK rising edge
bit_in  input  1  MOSI bit, valid when bit_valid=1
miso  output  1  current output bit; always the MSB of the transmit shifter
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  write data
mem_we  output  1  one-cycle write strobe
mem_re  output  1  one-cycle read strobe
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re
busy  output  1  high whenever state != IDLE
cmd_err  output  1  one-cycle pulse on an unknown opcode

Behaviour:
- Reset (async, rst=1): state=IDLE; bit_cnt=0; rx/tx shifters=0; mem_addr=0; mem_wdata=0. All outputs (mem_we, mem_re, cmd_err, miso, busy) are 0.
- Shifting: every bit_valid shifts bit_in into rx_shift LSB, MSB first. Bit counter is 3 bits; byte counter covers the address bytes.
- FSM states: IDLE, CMD, ADDR, WDATA, RFETCH, RDATA, IGNORE.
- IDLE -> CMD when cs_n=0. Counters are cleared.
- CMD: on the 8th bit_valid, compare the assembled byte:
  - CMD_READ -> ADDR, read flag set.
  - CMD_WRITE -> ADDR, read flag clear.
  - Any other value -> IGNORE, with cmd_err pulsed the following cycle.
- ADDR: after ADDR_W bits, mem_addr is loaded (MSB byte first). Read goes to RFETCH; write goes to WDATA.
- WDATA: on the 8th bit_valid, mem_wdata is loaded. mem_we=1 on the next cycle with the current mem_addr, and mem_addr increments in that same cycle. The FSM stays in WDATA for the burst.
- RFETCH: mem_re=1 for one cycle. On the following cycle, tx_shift<=mem_rdata and the FSM moves to RDATA. Total latency is 2 clk cycles; the SPI clock ratio guarantees this completes before the next bit_valid.
- RDATA: each bit_valid shifts tx_shift left, filling with 0. On the 8th, mem_addr increments and the FSM returns to RFETCH (burst).
- IGNORE: all bits are discarded and there are no strobes until cs_n rises.
- cs_n=1 in any state forces IDLE on the next cycle (abort):
  - a partial byte is discarded, with no mem_we/mem_re for it;
  - a strobe already asserted that cycle still completes;
  - tx_shift is cleared.
- If cs_n rises in the same cycle as the 8th bit_valid, the abort wins: no strobe is issued.
- mem_addr wraps from 2^ADDR_W-1 to 0.
- miso=0 outside RDATA.
- mem_we and mem_re are never high in the same cycle.

Decomposition:
- Package spi_pkg holds the state encoding localparams (3-bit), the CMD_READ/CMD_WRITE defaults and the ADDR_W/DATA_W defaults. The package is shared with the existing shift register.
- One natural sub-module: spi_bit_cnt. It is a 3-bit bit counter with a byte_done pulse and a sync clear on cs_n. It is instantiated once; the FSM counts address bytes off byte_done.

Test Plan:
- Write single: cs_n low, shift 0x02, 0x12, 0x34, 0xA5 -> one mem_we with mem_addr=0x1234, mem_wdata=0xA5; busy falls 1 cycle after cs_n rises.
- Read burst: 0x03, 0x00, 0x10, then 16 clocks; mem_rdata returns 0x5A then 0xC3 -> miso emits 01011010 11000011; mem_re fires at addr 0x0010 and 0x0011.
- Wrap: write 0x02, 0xFF, 0xFF, 0x11, 0x22 -> mem_we at 0xFFFF (0x11) then 0x0000 (0x22).
- Bad opcode 0x9F followed by 24 bits -> cmd_err one pulse; zero mem_we/mem_re; miso stays 0.
- Abort: cs_n rises after 5 data bits of a write -> no mem_we; next transaction decodes correctly from bit 0.
- Async reset asserted mid-RDATA -> all outputs 0 immediately, with no clk edge needed; state=IDLE.
